// File: rtl/hwag_pkg.sv
// Shared definitions for the hwag register block and its SSRAM-style arbiter:
// default bus widths, implemented register count and the access FSM states.
package hwag_pkg;

    localparam int HWAG_ADDR_W  = 8;
    localparam int HWAG_DATA_W  = 16;
    localparam int HWAG_REG_NUM = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } hwag_state_t;

endpackage

// File: rtl/hwag_rr_arb2.sv
// Two-way round-robin arbiter with a last-served pointer and one-hot grant.
// The pointer moves only when the owner of the current access finishes.
module hwag_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic [1:0] gnt
);

    logic last_q;

    // last-served pointer; resets to m1 so m0 wins the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= upd_idx;
        end
    end

    // one-hot grant; on contention the master not served last wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/hwag_ssram_arb.sv
// Two-master arbiter in front of the hwag register file, driving an
// SSRAM-like strobe interface with split tristate data
// (board level: ssram_data = ssram_oe ? ssram_wdata : 'z).
// Optional build macro HWAG_ARB_RANGE_CHECK_EN: accesses to addresses
// >= REG_NUM are rejected with err=1 and never reach hwag.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting; samples requests and latches the winner
// ST_SETUP  | address (and write data with oe) presented, no strobe
// ST_STROBE | single-cycle we/re strobe; read data captured at end
// ST_DONE   | ack (and err) to the granted master, oe released
module hwag_ssram_arb
    import hwag_pkg::*;
#(
    parameter int ADDR_W  = HWAG_ADDR_W,
    parameter int DATA_W  = HWAG_DATA_W,
    parameter int REG_NUM = HWAG_REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m_rdata,
    output logic              ssram_we,
    output logic              ssram_re,
    output logic [ADDR_W-1:0] ssram_addr,
    output logic [DATA_W-1:0] ssram_wdata,
    output logic              ssram_oe,
    input  logic [DATA_W-1:0] ssram_rdata
);

`ifdef HWAG_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    hwag_state_t       state_q;
    hwag_state_t       state_d;
    logic [1:0]        gnt;
    logic              accept;
    logic              sel_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_range_err;
    logic              idx_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              drive_bus;

    hwag_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1_req, m0_req}),
        .upd     (state_q == ST_DONE),
        .upd_idx (idx_q),
        .gnt     (gnt)
    );

    assign sel_idx   = gnt[1];
    assign sel_we    = sel_idx ? m1_we    : m0_we;
    assign sel_addr  = sel_idx ? m1_addr  : m0_addr;
    assign sel_wdata = sel_idx ? m1_wdata : m0_wdata;
    assign accept    = (state_q == ST_IDLE) && (|gnt);

    // constant-folds to 0 when the range check is not built in
    assign sel_range_err = RANGE_CHECK && (32'(sel_addr) >= 32'(REG_NUM));

    // state register; reset aborts any access in flight without an ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: fixed walk through the access phases, rejects skip to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    state_d = sel_range_err ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // latch the winner on acceptance; master inputs are ignored afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            idx_q   <= sel_idx;
            we_q    <= sel_we;
            err_q   <= sel_range_err;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
        end else if ((state_q == ST_STROBE) && !we_q) begin
            rdata_q <= ssram_rdata;
        end
    end

    // bus outputs decode straight from state so reset clears them at once
    assign drive_bus   = (state_q == ST_SETUP) || (state_q == ST_STROBE);
    assign ssram_addr  = drive_bus ? addr_q : '0;
    assign ssram_wdata = (drive_bus && we_q) ? wdata_q : '0;
    assign ssram_oe    = drive_bus && we_q;
    assign ssram_we    = (state_q == ST_STROBE) && we_q;
    assign ssram_re    = (state_q == ST_STROBE) && !we_q;

    assign m0_ack  = (state_q == ST_DONE) && !idx_q;
    assign m1_ack  = (state_q == ST_DONE) && idx_q;
    assign m0_err  = (state_q == ST_DONE) && !idx_q && err_q;
    assign m1_err  = (state_q == ST_DONE) && idx_q && err_q;
    assign m_rdata = (state_q == ST_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_hwag_ssram_arb.sv
// Self-checking bench for hwag_ssram_arb: directed scenarios followed by
// random two-master traffic, checked against an access-level model.
module tb_hwag_ssram_arb;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int REG_NUM = 64;

`ifdef HWAG_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic [DATA_W-1:0] m_rdata;
    logic              ssram_we, ssram_re, ssram_oe;
    logic [ADDR_W-1:0] ssram_addr;
    logic [DATA_W-1:0] ssram_wdata, ssram_rdata;

    int checks = 0;
    int errors = 0;

    // hwag register file model
    logic [DATA_W-1:0] mem    [256];
    bit                wr_vld [256];

    // access-level reference state
    logic [DATA_W-1:0] ref_mem [256];
    bit                pend    [2];
    bit                t_we    [2];
    logic [ADDR_W-1:0] t_addr  [2];
    logic [DATA_W-1:0] t_wdata [2];
    int                last_srv;
    int                cyc;
    int                last_ack_cyc;
    int                ack_gap;
    bit                in_done;

    always #5 clk = ~clk;

    hwag_ssram_arb dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m0_ack      (m0_ack),
        .m0_err      (m0_err),
        .m1_ack      (m1_ack),
        .m1_err      (m1_err),
        .m_rdata     (m_rdata),
        .ssram_we    (ssram_we),
        .ssram_re    (ssram_re),
        .ssram_addr  (ssram_addr),
        .ssram_wdata (ssram_wdata),
        .ssram_oe    (ssram_oe),
        .ssram_rdata (ssram_rdata)
    );

    // power-up contents of the hwag registers; address 5 reads 0x1234
    function automatic logic [DATA_W-1:0] hw_init(input logic [ADDR_W-1:0] a);
        return 16'h1234 ^ {8'h00, a ^ 8'd5};
    endfunction

    assign ssram_rdata = wr_vld[ssram_addr] ? mem[ssram_addr] : hw_init(ssram_addr);

    // hwag write port
    always @(posedge clk) begin
        if (ssram_we) begin
            mem[ssram_addr]    <= ssram_wdata;
            wr_vld[ssram_addr] <= 1'b1;
        end
    end

    // bus invariants every cycle
    always @(negedge clk) begin
        checks++;
        assert (!(ssram_we && ssram_re)) else begin
            errors++;
            $error("FAIL we_re_excl: observed we=%0b re=%0b required not both", ssram_we, ssram_re);
        end
        checks++;
        assert (!((ssram_we || ssram_re) && (m0_ack || m1_ack))) else begin
            errors++;
            $error("FAIL strobe_with_ack: observed strobe during ack, required none");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        m0_req   = pend[0];
        m0_we    = t_we[0];
        m0_addr  = t_addr[0];
        m0_wdata = t_wdata[0];
        m1_req   = pend[1];
        m1_we    = t_we[1];
        m1_addr  = t_addr[1];
        m1_wdata = t_wdata[1];
    endtask

    task automatic issue(input int m, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        pend[m]    = 1'b1;
        t_we[m]    = we;
        t_addr[m]  = a;
        t_wdata[m] = d;
        drive();
    endtask

    task automatic rand_issue(input int m);
        logic [ADDR_W-1:0] a;
        if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(REG_NUM, 255));
        else                           a = 8'($urandom_range(0, REG_NUM - 1));
        issue(m, 1'($urandom_range(0, 1)), a, 16'($urandom));
    endtask

    task automatic new_reqs();
        for (int m = 0; m < 2; m++) begin
            if (!pend[m] && ($urandom_range(0, 2) != 0)) rand_issue(m);
        end
        if (!pend[0] && !pend[1]) rand_issue(int'($urandom_range(0, 1)));
    endtask

    // one complete access from the model's point of view; returns the winner
    task automatic serve(output int g);
        bit                exp_err;
        int                ack_c;
        logic [DATA_W-1:0] exp_rd;
        logic [1:0]        ackv;
        bit                done;
        if (pend[0] && pend[1]) g = (last_srv == 1) ? 0 : 1;
        else if (pend[0])       g = 0;
        else                    g = 1;
        exp_err = RANGE_EN && (t_addr[g] >= 8'(REG_NUM));
        ack_c   = exp_err ? 1 : 3;
        exp_rd  = exp_err ? 16'h0000 : ref_mem[t_addr[g]];
        if (in_done) begin
            @(negedge clk);
            cyc++;
            chk("idle_quiet", 32'({m1_ack, m0_ack, ssram_we, ssram_re, ssram_oe}), 32'd0);
        end
        done = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            cyc++;
            ackv = {m1_ack, m0_ack};
            chk("strobe_timing", 32'(ssram_we | ssram_re), 32'((c == 2) && !exp_err));
            if (c == 1 && !exp_err) begin
                chk("setup_addr", 32'(ssram_addr), 32'(t_addr[g]));
                chk("setup_oe", 32'(ssram_oe), 32'(t_we[g]));
            end
            if (c == 2 && !exp_err) begin
                chk("strobe_we", 32'(ssram_we), 32'(t_we[g]));
                chk("strobe_addr", 32'(ssram_addr), 32'(t_addr[g]));
                chk("strobe_oe", 32'(ssram_oe), 32'(t_we[g]));
                if (t_we[g]) chk("strobe_wdata", 32'(ssram_wdata), 32'(t_wdata[g]));
            end
            if (ackv != 2'b00 || c == ack_c) begin
                done = 1'b1;
                chk("ack_latency", 32'(c), 32'(ack_c));
                chk("ack_master", 32'(ackv), (g == 0) ? 32'd1 : 32'd2);
                chk("ack_err", 32'({m1_err, m0_err}), exp_err ? ((g == 0) ? 32'd1 : 32'd2) : 32'd0);
                chk("done_oe", 32'(ssram_oe), 32'd0);
                if (!t_we[g] || exp_err) chk("rdata", 32'(m_rdata), 32'(exp_rd));
            end
        end
        if (t_we[g] && !exp_err) ref_mem[t_addr[g]] = t_wdata[g];
        last_srv     = g;
        ack_gap      = cyc - last_ack_cyc;
        last_ack_cyc = cyc;
        pend[g]      = 1'b0;
        drive();
        in_done = 1'b1;
    endtask

    initial begin
        int g;
        for (int i = 0; i < 256; i++) ref_mem[i] = hw_init(8'(i));
        for (int m = 0; m < 2; m++) begin
            pend[m] = 1'b0; t_we[m] = 1'b0; t_addr[m] = '0; t_wdata[m] = '0;
        end
        drive();
        last_srv = 1; cyc = 0; last_ack_cyc = 0; ack_gap = 0; in_done = 1'b0;

        // reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({ssram_we, ssram_re, ssram_oe}), 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        chk("rst_addr", 32'(ssram_addr), 32'd0);
        chk("rst_wdata", 32'(ssram_wdata), 32'd0);
        chk("rst_rdata", 32'(m_rdata), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'({ssram_we, ssram_re, m0_ack, m1_ack}), 32'd0);

        // m0 writes 3 to register 0
        issue(0, 1'b1, 8'd0, 16'd3);
        serve(g);
        chk("w0_m0_ack", 32'(m0_ack), 32'd1);

        // m1 reads register 5
        issue(1, 1'b0, 8'd5, 16'd0);
        serve(g);
        chk("r5_m1_ack", 32'(m1_ack), 32'd1);
        chk("r5_rdata", 32'(m_rdata), 32'h1234);
        chk("r5_err", 32'(m1_err), 32'd0);

        // both masters request together and keep requesting
        issue(0, 1'b1, 8'd10, 16'hA0A0);
        issue(1, 1'b0, 8'd0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            serve(g);
            chk("rr_m1_ack", 32'(m1_ack), 32'(i % 2));
            if (i > 0) chk("rr_gap", 32'(ack_gap), 32'd4);
            if (i < 3) issue(g, 1'b0, 8'(10 + i), 16'd0);
        end
        serve(g);

        // reset in the middle of a strobe
        issue(0, 1'b1, 8'd20, 16'h5555);
        issue(1, 1'b1, 8'd21, 16'h6666);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_strobe", 32'(ssram_we), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_strobes", 32'({ssram_we, ssram_re, ssram_oe}), 32'd0);
        chk("abort_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        chk("abort_addr", 32'(ssram_addr), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_quiet", 32'({m0_ack, m1_ack, ssram_we, ssram_re}), 32'd0);
        end
        rst = 1'b1;
        last_srv = 1; in_done = 1'b0; cyc = 0; last_ack_cyc = 0;
        serve(g);
        chk("post_rst_m0", 32'(m0_ack), 32'd1);
        serve(g);
        chk("post_rst_m1", 32'(m1_ack), 32'd1);

        // register address just past the implemented range
        issue(0, 1'b0, 8'(REG_NUM), 16'd0);
        serve(g);
        chk("oor_err", 32'(m0_err), 32'(RANGE_EN));

        // random traffic
        for (int n = 0; n < 60; n++) begin
            new_reqs();
            serve(g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwag_ssram_arb.md
HWAG_SSRAM_ARB -- requirements
Module: hwag_ssram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, the register-bus address width.
REQ-002 SHALL have parameter DATA_W, default 16, the register-bus data width.
REQ-003 SHALL have parameter REG_NUM, default 64, the number of implemented hwag registers (valid addresses 0..REG_NUM-1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req / m1_req, input, 1 bit each: access request; held high until the matching ack.
REQ-007 SHALL have ports m0_we / m1_we, input, 1 bit each: 1 = write, 0 = read; qualified by req.
REQ-008 SHALL have ports m0_addr / m1_addr, input, ADDR_W each: register address.
REQ-009 SHALL have ports m0_wdata / m1_wdata, input, DATA_W each: write data.
REQ-010 SHALL have ports m0_ack / m1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have ports m0_err / m1_err, output, 1 bit each: valid with ack; 1 = access rejected.
REQ-012 SHALL have port m_rdata, output, DATA_W: read data; valid while either ack is high.
REQ-013 SHALL have ports ssram_we / ssram_re, output, 1 bit each: hwag write and read strobes.
REQ-014 SHALL have port ssram_addr, output, ADDR_W: hwag register address.
REQ-015 SHALL have ports ssram_wdata (output, DATA_W), ssram_oe (output, 1) and ssram_rdata (input, DATA_W): split tristate data; the top level drives ssram_data = ssram_oe ? ssram_wdata : Z.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> STROBE -> DONE -> IDLE, one cycle per non-IDLE state.
REQ-017 In IDLE with any req high, SHALL grant one master, latch its we/addr/wdata, and go to SETUP; with no req, SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, grant the master not served last; the last-served pointer updates in DONE.
REQ-019 SETUP SHALL drive ssram_addr and, for a write, ssram_wdata with ssram_oe=1; both strobes stay 0.
REQ-020 STROBE SHALL assert exactly one of ssram_we or ssram_re for one cycle, with addr/wdata/oe held.
REQ-021 At the end of STROBE for a read, SHALL capture ssram_rdata into m_rdata.
REQ-022 DONE SHALL pulse the granted master's ack for one cycle and deassert ssram_oe.
REQ-023 Latency from the IDLE acceptance edge to ack SHALL be 3 cycles; throughput SHALL be one access per 4 cycles.
REQ-024 Requests SHALL be sampled only in IDLE; req or data changes in other states SHALL be ignored.
REQ-025 The master SHALL drop or renew req in the cycle after ack; a req still high in the IDLE that follows SHALL be treated as a new access.
REQ-026 ssram_we and ssram_re SHALL never be high together, and SHALL never be high outside STROBE.

Reset
REQ-027 Reset SHALL force state=IDLE, last-served=m1 (so m0 wins first), and all outputs to 0 (ssram_oe=0); this SHALL take effect immediately, mid-access included, with no ack for the aborted access.

Configuration
REQ-028 With HWAG_ARB_RANGE_CHECK_EN defined, an address >= REG_NUM SHALL skip SETUP/STROBE (IDLE -> DONE) and give ack with err=1, no strobes, and m_rdata=0.
REQ-029 Without HWAG_ARB_RANGE_CHECK_EN, every address SHALL be passed to hwag, and err SHALL be tied to 0.

Structure
REQ-030 The FSM state enum and the default widths/REG_NUM SHALL live in package hwag_pkg, shared with hwag.
REQ-031 The round-robin grant logic SHALL be a sub-module hwag_rr_arb2 (2 requests, last-served pointer, one-hot grant).

Verification
REQ-032 Reset release, m0 writes addr 0 data 3 -> ssram_we is high exactly one cycle with addr=0, wdata=3, oe=1; m0_ack follows 3 cycles after acceptance.
REQ-033 m1 reads addr 5 with hwag model returning 0x1234 -> ssram_re is high one cycle; m1_ack with m_rdata=0x1234 and err=0.
REQ-034 m0 and m1 request in the same cycle and hold -> grants alternate m0, m1, m0, m1 over 4 accesses, 4 cycles each.
REQ-035 rst low during STROBE -> all outputs 0 the same cycle, no ack; after release, the pending m0 req is served from IDLE.
REQ-036 With HWAG_ARB_RANGE_CHECK_EN, an access to addr 64 -> ack with err=1, no strobe; without the macro, a strobe with addr=64 and err=0.
REQ-037 Throughout all tests, a checker SHALL assert we&re is never 1 and no strobe occurs outside STROBE.
